// File: rtl/store_drain.sv
// store_drain: drains committed stores from the store queue head to memory, one write in flight.
// Optional STORE_DRAIN_PERF_EN adds drained-store and request-stall counters.
module store_drain #(
    parameter int ROB_IDX_WIDTH = 6,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_PENDING   = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic                               commit_store_i,
    input  logic                               sq_head_valid_i,
    input  logic [ROB_IDX_WIDTH-1:0]           sq_head_rob_tag_i,
    input  logic [ADDR_WIDTH-1:0]              sq_head_addr_i,
    input  logic [DATA_WIDTH-1:0]              sq_head_data_i,
    input  logic [DATA_WIDTH/8-1:0]            sq_head_be_i,
    output logic                               sq_pop_valid_o,
    input  logic                               sq_pop_ready_i,
    output logic                               mem_req_valid_o,
    input  logic                               mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]              mem_req_data_o,
    output logic [DATA_WIDTH/8-1:0]            mem_req_be_o,
    output logic [ROB_IDX_WIDTH-1:0]           mem_req_tag_o,
    input  logic                               mem_resp_valid_i,
    input  logic                               mem_resp_err_i,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_o,
    output logic                               busy_o,
    output logic                               err_o,
    output logic [31:0]                        perf_drained_o,
    output logic [31:0]                        perf_stall_o
);
    localparam int PW = $clog2(MAX_PENDING+1);
    localparam int BW = DATA_WIDTH/8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

    state_t                     state_q, state_d;
    logic [PW-1:0]              pending_q, pending_d;
    logic                       err_q, err_d;
    logic                       req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [BW-1:0]              be_q, be_d;
    logic [ROB_IDX_WIDTH-1:0]   tag_q, tag_d;
    logic                       resp_fire, pop_fire, overflow;

    // Committed stores are architectural, so flush never alters the drain.
    logic flush_unused;
    assign flush_unused = flush_i;

    always_comb begin
        resp_fire = (state_q == WAIT_RESP) && mem_resp_valid_i && !rst_i;
        pop_fire  = resp_fire && sq_pop_ready_i;
        overflow  = commit_store_i && !pop_fire && (pending_q == PW'(MAX_PENDING));
        pending_d = (commit_store_i && !pop_fire && !overflow) ? pending_q + PW'(1) :
                    (pop_fire && !commit_store_i)              ? pending_q - PW'(1) : pending_q;
        err_d     = err_q | overflow | (resp_fire && (mem_resp_err_i || !sq_pop_ready_i));
        state_d     = state_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        tag_d       = tag_q;
        case (state_q)
            IDLE: if (sq_head_valid_i && pending_q != '0) begin
                state_d     = REQ;
                req_valid_d = 1'b1;
                addr_d      = sq_head_addr_i;
                data_d      = sq_head_data_i;
                be_d        = sq_head_be_i;
                tag_d       = sq_head_rob_tag_i;
            end
            REQ: if (mem_req_ready_i) begin
                state_d     = WAIT_RESP;
                req_valid_d = 1'b0;
            end
            WAIT_RESP: state_d = mem_resp_valid_i ? IDLE : WAIT_RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            tag_q       <= tag_d;
        end
    end

    assign sq_pop_valid_o  = resp_fire;
    assign mem_req_valid_o = req_valid_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_data_o  = data_q;
    assign mem_req_be_o    = be_q;
    assign mem_req_tag_o   = tag_q;
    assign pending_o       = pending_q;
    assign busy_o          = state_q != IDLE;
    assign err_o           = err_q;

`ifdef STORE_DRAIN_PERF_EN
    logic [31:0] drained_q, drained_d, stall_q, stall_d;

    always_comb begin
        drained_d = drained_q + {31'd0, pop_fire};
        stall_d   = stall_q + {31'd0, (state_q == REQ) && !mem_req_ready_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drained_q <= '0;
            stall_q   <= '0;
        end else begin
            drained_q <= drained_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_drained_o = drained_q;
    assign perf_stall_o   = stall_q;
`else
    assign perf_drained_o = '0;
    assign perf_stall_o   = '0;
`endif
endmodule

// File: tb/tb_store_drain.sv
// tb_store_drain: directed stimulus with a request scoreboard checked by a separate monitor.
module tb_store_drain;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [5:0]  tag;
    } pl_t;

    logic        clk_i = 0, rst_i = 1, flush_i = 0, commit_store_i = 0;
    logic        sq_head_valid_i = 0, sq_pop_ready_i = 1, mem_req_ready_i = 0;
    logic        mem_resp_valid_i = 0, mem_resp_err_i = 0;
    logic [5:0]  sq_head_rob_tag_i = 0;
    logic [31:0] sq_head_addr_i = 0, sq_head_data_i = 0;
    logic [3:0]  sq_head_be_i = 0;
    logic        sq_pop_valid_o, mem_req_valid_o, busy_o, err_o;
    logic [31:0] mem_req_addr_o, mem_req_data_o, perf_drained_o, perf_stall_o;
    logic [3:0]  mem_req_be_o;
    logic [5:0]  mem_req_tag_o;
    logic [4:0]  pending_o;

    int   n_tests = 0, n_fail = 0;
    int   exp_drained = 0, exp_stall = 0;
    bit   perf_en;
    pl_t  exp_q[$];

    store_drain dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .commit_store_i(commit_store_i),
        .sq_head_valid_i(sq_head_valid_i), .sq_head_rob_tag_i(sq_head_rob_tag_i),
        .sq_head_addr_i(sq_head_addr_i), .sq_head_data_i(sq_head_data_i),
        .sq_head_be_i(sq_head_be_i), .sq_pop_valid_o(sq_pop_valid_o),
        .sq_pop_ready_i(sq_pop_ready_i), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_data_o(mem_req_data_o), .mem_req_be_o(mem_req_be_o),
        .mem_req_tag_o(mem_req_tag_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_err_i(mem_resp_err_i), .pending_o(pending_o), .busy_o(busy_o),
        .err_o(err_o), .perf_drained_o(perf_drained_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic pl_t cur_pl();
        return '{mem_req_addr_o, mem_req_data_o, mem_req_be_o, mem_req_tag_o};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted write request must match the next expected store.
    always @(negedge clk_i) begin
        if (!rst_i && mem_req_valid_o && mem_req_ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_req: got %0h expected none", cur_pl());
            end else begin
                check("req_payload", 128'(cur_pl()), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_head(input pl_t p, input bit v);
        sq_head_valid_i   = v;
        sq_head_addr_i    = p.addr;
        sq_head_data_i    = p.data;
        sq_head_be_i      = p.be;
        sq_head_rob_tag_i = p.tag;
    endtask

    task automatic commits(input int n);
        commit_store_i = 1;
        repeat (n) tick();
        commit_store_i = 0;
    endtask

    task automatic serve(input int stall, input bit rerr, input bit pr, input bit cm, input bit fl);
        int k = 0;
        pl_t first;
        flush_i = fl;
        while (!mem_req_valid_o && k < 10) begin
            tick();
            k++;
        end
        check("req_seen", 128'(mem_req_valid_o), 128'(1));
        first = cur_pl();
        for (int i = 0; i < stall; i++) begin
            tick();
            check("hold_valid", 128'(mem_req_valid_o), 128'(1));
            check("hold_payload", 128'(cur_pl()), 128'(first));
        end
        exp_stall += stall;
        mem_req_ready_i = 1;
        tick();
        mem_req_ready_i = 0;
        check("wait_busy", 128'(busy_o), 128'(1));
        mem_resp_valid_i = 1;
        mem_resp_err_i   = rerr;
        sq_pop_ready_i   = pr;
        commit_store_i   = cm;
        #1;
        check("pop_valid", 128'(sq_pop_valid_o), 128'(1));
        if (pr) exp_drained++;
        tick();
        mem_resp_valid_i = 0;
        mem_resp_err_i   = 0;
        sq_pop_ready_i   = 1;
        commit_store_i   = 0;
        flush_i          = 0;
        check("idle_after", 128'(busy_o), 128'(0));
    endtask

    initial begin
        pl_t a = '{32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 6'd5};
        pl_t b = '{32'h0000_1000, 32'h1111_2222, 4'h3, 6'd10};
        pl_t c = '{32'h0000_1004, 32'h3333_4444, 4'hC, 6'd11};
        pl_t d = '{32'h0000_1008, 32'h5555_6666, 4'h1, 6'd12};
`ifdef STORE_DRAIN_PERF_EN
        perf_en = 1;
`else
        perf_en = 0;
`endif
        tick();
        tick();
        check("rst_valid", 128'(mem_req_valid_o), 128'(0));
        check("rst_pop", 128'(sq_pop_valid_o), 128'(0));
        check("rst_pending", 128'(pending_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_err", 128'(err_o), 128'(0));
        check("rst_payload", 128'(cur_pl()), 128'(0));
        check("rst_perf", 128'({perf_drained_o, perf_stall_o}), 128'(0));
        rst_i = 0;
        tick();
        // Single store: request two cycles after commit, pop on the response cycle.
        set_head(a, 1);
        exp_q.push_back(a);
        commit_store_i = 1;
        tick();
        commit_store_i = 0;
        check("t1_pending1", 128'(pending_o), 128'(1));
        check("t1_no_req_yet", 128'(mem_req_valid_o), 128'(0));
        tick();
        check("t1_req_cycle2", 128'(mem_req_valid_o), 128'(1));
        serve(0, 0, 1, 0, 0);
        check("t1_pending0", 128'(pending_o), 128'(0));
        // Three stores, first request stalled four cycles.
        set_head(b, 0);
        commits(3);
        check("t2_pending3", 128'(pending_o), 128'(3));
        set_head(b, 1);
        exp_q.push_back(b);
        serve(4, 0, 1, 0, 0);
        check("t2_pending2", 128'(pending_o), 128'(2));
        set_head(c, 1);
        exp_q.push_back(c);
        serve(0, 0, 1, 0, 0);
        set_head(d, 1);
        exp_q.push_back(d);
        serve(0, 0, 1, 0, 0);
        check("t2_pending0", 128'(pending_o), 128'(0));
        check("t2_perf_stall", 128'(perf_stall_o), 128'(perf_en ? exp_stall : 0));
        check("t2_perf_drained", 128'(perf_drained_o), 128'(perf_en ? exp_drained : 0));
        // Commit coinciding with a pop leaves pending unchanged.
        set_head(b, 0);
        commits(2);
        check("t3_pending2", 128'(pending_o), 128'(2));
        set_head(b, 1);
        exp_q.push_back(b);
        serve(0, 0, 1, 1, 0);
        check("t3_same_cycle", 128'(pending_o), 128'(2));
        set_head(c, 1);
        exp_q.push_back(c);
        serve(0, 0, 1, 0, 0);
        set_head(d, 1);
        exp_q.push_back(d);
        serve(0, 0, 1, 0, 0);
        check("t3_pending0", 128'(pending_o), 128'(0));
        // Flush in IDLE preserves pending; flush mid-transaction completes it.
        set_head(a, 0);
        commits(1);
        flush_i = 1;
        tick();
        flush_i = 0;
        check("t4_flush_idle", 128'(pending_o), 128'(1));
        set_head(a, 1);
        exp_q.push_back(a);
        serve(0, 0, 1, 0, 1);
        check("t4_pending0", 128'(pending_o), 128'(0));
        check("t4_err0", 128'(err_o), 128'(0));
        // Pop refused at response time: error, entry kept and re-sent.
        set_head(c, 0);
        commits(1);
        set_head(c, 1);
        exp_q.push_back(c);
        serve(0, 0, 0, 0, 0);
        check("t5_err", 128'(err_o), 128'(1));
        check("t5_pending_kept", 128'(pending_o), 128'(1));
        exp_q.push_back(c);
        serve(0, 0, 1, 0, 0);
        check("t5_pending0", 128'(pending_o), 128'(0));
        check("t5_err_sticky", 128'(err_o), 128'(1));
        // Overflow past MAX_PENDING.
        rst_i = 1;
        tick();
        rst_i = 0;
        check("t6_err_cleared", 128'(err_o), 128'(0));
        set_head(d, 0);
        commits(16);
        check("t6_pending16", 128'(pending_o), 128'(16));
        check("t6_err_before", 128'(err_o), 128'(0));
        commits(1);
        check("t6_pending_sat", 128'(pending_o), 128'(16));
        check("t6_err_overflow", 128'(err_o), 128'(1));
        set_head(d, 1);
        exp_q.push_back(d);
        serve(0, 1, 1, 0, 0);
        check("t6_pending15", 128'(pending_o), 128'(15));
        check("t6_err_stays", 128'(err_o), 128'(1));
        // Reset during REQ, then a late response must be ignored.
        set_head(a, 0);
        rst_i = 1;
        tick();
        rst_i = 0;
        commits(1);
        set_head(a, 1);
        tick();
        check("t7_in_req", 128'(mem_req_valid_o), 128'(1));
        rst_i = 1;
        tick();
        rst_i = 0;
        set_head(a, 0);
        check("t7_valid0", 128'(mem_req_valid_o), 128'(0));
        check("t7_busy0", 128'(busy_o), 128'(0));
        check("t7_pending0", 128'(pending_o), 128'(0));
        mem_resp_valid_i = 1;
        mem_resp_err_i   = 1;
        #1;
        check("t7_late_pop", 128'(sq_pop_valid_o), 128'(0));
        tick();
        mem_resp_valid_i = 0;
        mem_resp_err_i   = 0;
        check("t7_late_err", 128'(err_o), 128'(0));
        check("t7_late_busy", 128'(busy_o), 128'(0));
        tick();
        check("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
